// File: rtl/imem_loader.sv
// Instruction memory with a registered fetch port and a byte-serial loader
// that packs UART bytes MSB-first into words written from word 0 upward.
module imem_loader #(
   parameter int unsigned ADDR_W    = 11,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_req,
   input  logic [31:0]       pc,
   output logic              fetch_valid,
   output logic [31:0]       instr,
   output logic              fetch_fault,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_words,
   input  logic              load_byte_valid,
   input  logic [7:0]        load_byte,
   output logic              load_busy,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count
);

   localparam int unsigned     DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_W   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [32:0]     LAST_OFF  = (33'd4 << ADDR_W) - 33'd1;

   typedef enum logic {RUN, LOAD} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     target_q, target_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W-1:0]   wordPtr_q, wordPtr_d;
   logic [1:0]          byteIdx_q, byteIdx_d;
   logic [31:0]         assembly_q, assembly_d;
   logic                done_q, done_d;

   logic                memWe;
   logic [31:0]         memWdata;
   logic [ADDR_W:0]     clampedWords;
   logic [ADDR_W:0]     countNext;

   logic [31:0]         mem [DEPTH];

   logic [32:0]         offsetWide;
   logic                fetchFault;
   logic [ADDR_W-1:0]   fetchIdx;
   logic                fetchAccept;

   logic                fetchValid_q;
   logic [31:0]         instr_q;
   logic                fault_q;

   assign clampedWords = (load_words > DEPTH_W) ? DEPTH_W : load_words;
   assign countNext    = count_q + COUNT_ONE;

   // A pc below the window borrows into bit 32, so one 33-bit compare covers both bounds.
   assign offsetWide  = {1'b0, pc} - {1'b0, BASE_ADDR};
   assign fetchFault  = (pc[1:0] != 2'b00) || (offsetWide > LAST_OFF);
   assign fetchIdx    = offsetWide[ADDR_W+1:2];
   assign fetchAccept = fetch_req && (state_q == RUN);

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      count_d    = count_q;
      wordPtr_d  = wordPtr_q;
      byteIdx_d  = byteIdx_q;
      assembly_d = assembly_q;
      done_d     = 1'b0;
      memWe      = 1'b0;
      memWdata   = {assembly_q[23:0], load_byte};
      unique case (state_q)
         RUN: begin
            if (load_start) begin
               target_d  = clampedWords;
               count_d   = '0;
               wordPtr_d = '0;
               byteIdx_d = '0;
               if (clampedWords == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (load_byte_valid) begin
               assembly_d = {assembly_q[23:0], load_byte};
               byteIdx_d  = byteIdx_q + 2'd1;
               if (byteIdx_q == 2'd3) begin
                  memWe     = 1'b1;
                  wordPtr_d = wordPtr_q + PTR_ONE;
                  count_d   = countNext;
                  if (countNext == target_q) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RUN;
         target_q   <= '0;
         count_q    <= '0;
         wordPtr_q  <= '0;
         byteIdx_q  <= '0;
         assembly_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         count_q    <= count_d;
         wordPtr_q  <= wordPtr_d;
         byteIdx_q  <= byteIdx_d;
         assembly_q <= assembly_d;
         done_q     <= done_d;
      end
   end

   // Storage is left out of reset so it maps onto block RAM and survives a reset mid-load.
   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[wordPtr_q] <= memWdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetchValid_q <= 1'b0;
         instr_q      <= '0;
         fault_q      <= 1'b0;
      end else begin
         fetchValid_q <= fetchAccept;
         if (fetchAccept) begin
            fault_q <= fetchFault;
            instr_q <= fetchFault ? FILL_WORD : mem[fetchIdx];
         end
      end
   end

   assign fetch_valid = fetchValid_q;
   assign instr       = instr_q;
   assign fetch_fault = fault_q;
   assign load_busy   = (state_q == LOAD);
   assign load_done   = done_q;
   assign load_count  = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a word-array reference model predicts every
// fetch response and load completion, and a negedge monitor checks them.
module tb_imem_loader;

   localparam int          ADDR_W = 11;
   localparam int          DEPTH  = 1 << ADDR_W;
   localparam logic [31:0] FILL   = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              fetch_req;
   logic [31:0]       pc;
   logic              fetch_valid;
   logic [31:0]       instr;
   logic              fetch_fault;
   logic              load_start;
   logic [ADDR_W:0]   load_words;
   logic              load_byte_valid;
   logic [7:0]        load_byte;
   logic              load_busy;
   logic              load_done;
   logic [ADDR_W:0]   load_count;

   always #5 clk = ~clk;

   imem_loader #(
      .ADDR_W(ADDR_W),
      .BASE_ADDR(32'h0000_0000),
      .FILL_WORD(FILL)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .fetch_req(fetch_req),
      .pc(pc),
      .fetch_valid(fetch_valid),
      .instr(instr),
      .fetch_fault(fetch_fault),
      .load_start(load_start),
      .load_words(load_words),
      .load_byte_valid(load_byte_valid),
      .load_byte(load_byte),
      .load_busy(load_busy),
      .load_done(load_done),
      .load_count(load_count)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic        fault;
   } fetchExp_t;

   int          nCompared   = 0;
   int          nMismatched = 0;
   logic [31:0] refMem [DEPTH];
   fetchExp_t   fetchQ [$];
   int          doneQ [$];
   logic [7:0]  byteSrc [$];
   fetchExp_t   lastExp;
   fetchExp_t   monExp;
   int          monDone;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic fetchExp_t refFetch(input logic [31:0] addr);
      fetchExp_t       r;
      longint unsigned a;
      a       = addr;
      r.fault = ((a % 4) != 0) || (a >= 4 * DEPTH);
      r.instr = r.fault ? FILL : refMem[int'(a / 4)];
      return r;
   endfunction

   task automatic issueFetch(input logic [31:0] addr);
      fetch_req = 1'b1;
      pc        = addr;
      lastExp   = refFetch(addr);
      fetchQ.push_back(lastExp);
      @(negedge clk);
   endtask

   // Drives one load; bytesToSend short of the full length leaves the load unfinished.
   task automatic applyStimulus(input int reqWords, input int bytesToSend, input bit gaps,
                                input bit holdFetch, input bit restart);
      int          target;
      int          wordIdx;
      bit          full;
      logic [31:0] word;
      logic [7:0]  v;
      target  = (reqWords > DEPTH) ? DEPTH : reqWords;
      wordIdx = 0;
      word    = '0;
      full    = (bytesToSend >= target * 4);
      if (full) doneQ.push_back(target);
      load_start = 1'b1;
      load_words = (ADDR_W+1)'(reqWords);
      @(negedge clk);
      load_start = 1'b0;
      if (target == 0) begin
         checkOutput("zeroLoadDone", {31'b0, load_done}, 32'd1);
         checkOutput("zeroLoadBusy", {31'b0, load_busy}, 32'd0);
         @(negedge clk);
         checkOutput("zeroLoadDoneFalls", {31'b0, load_done}, 32'd0);
         checkOutput("zeroLoadBusyStaysLow", {31'b0, load_busy}, 32'd0);
         return;
      end
      checkOutput("loadBusyRise", {31'b0, load_busy}, 32'd1);
      fetch_req = holdFetch;
      pc        = 32'h0;
      for (int b = 0; b < bytesToSend; b++) begin
         if (gaps) begin
            while ($urandom_range(2) == 0) begin
               load_byte_valid = 1'b0;
               load_byte       = 8'($urandom);
               @(negedge clk);
            end
         end
         v = (byteSrc.size() > 0) ? byteSrc.pop_front() : 8'($urandom);
         load_byte_valid = 1'b1;
         load_byte       = v;
         if (restart && b == 2) begin
            load_start = 1'b1;
            load_words = (ADDR_W+1)'(1);
         end
         word = {word[23:0], v};
         @(negedge clk);
         load_start = 1'b0;
         if ((b % 4) == 3) begin
            refMem[wordIdx] = word;
            wordIdx++;
         end
         if (full && b < bytesToSend - 1) begin
            if (load_done) checkOutput("loadDoneEarly", {31'b0, load_done}, 32'd0);
         end
      end
      load_byte_valid = 1'b0;
      fetch_req       = 1'b0;
      if (full) begin
         checkOutput("loadDoneOnLastByte", {31'b0, load_done}, 32'd1);
         checkOutput("loadBusyFalls", {31'b0, load_busy}, 32'd0);
         checkOutput("loadCountFinal", 32'(load_count), 32'(target));
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_fetch_valid"}, {31'b0, fetch_valid}, 32'd0);
      checkOutput({tag, "_instr"}, instr, 32'd0);
      checkOutput({tag, "_fetch_fault"}, {31'b0, fetch_fault}, 32'd0);
      checkOutput({tag, "_load_busy"}, {31'b0, load_busy}, 32'd0);
      checkOutput({tag, "_load_done"}, {31'b0, load_done}, 32'd0);
      checkOutput({tag, "_load_count"}, 32'(load_count), 32'd0);
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (fetch_valid) begin
            if (fetchQ.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL unexpectedFetchValid: got fetch_valid=1, expected 0");
            end else begin
               monExp = fetchQ.pop_front();
               checkOutput("fetchInstr", instr, monExp.instr);
               checkOutput("fetchFault", {31'b0, fetch_fault}, {31'b0, monExp.fault});
            end
         end
         if (load_done) begin
            if (doneQ.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL unexpectedLoadDone: got load_done=1, expected 0");
            end else begin
               monDone = doneQ.pop_front();
               checkOutput("doneLoadCount", 32'(load_count), 32'(monDone));
            end
         end
      end
   end

   initial begin
      logic [31:0] addr;
      reset_n         = 1'b0;
      fetch_req       = 1'b0;
      pc              = '0;
      load_start      = 1'b0;
      load_words      = '0;
      load_byte_valid = 1'b0;
      load_byte       = '0;
      #12;
      checkResetOutputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // 4095 is the largest request the port can carry; it clamps to the full depth.
      applyStimulus(4095, 4 * DEPTH, 1'b0, 1'b0, 1'b0);

      issueFetch(32'h0000_1FFC);
      issueFetch(32'h0000_2000);
      issueFetch(32'h0000_0002);
      issueFetch(32'hFFFF_FFFC);
      issueFetch(32'h0000_0000);
      repeat (60) begin
         case ($urandom_range(3))
            0, 1:    addr = 32'($urandom_range(DEPTH - 1)) << 2;
            2:       addr = 32'($urandom_range(4 * DEPTH - 1));
            default: addr = $urandom;
         endcase
         issueFetch(addr);
      end
      fetch_req = 1'b0;
      @(negedge clk);
      checkOutput("idleFetchValid", {31'b0, fetch_valid}, 32'd0);
      checkOutput("idleInstrHold", instr, lastExp.instr);
      checkOutput("idleFaultHold", {31'b0, fetch_fault}, {31'b0, lastExp.fault});

      byteSrc = '{8'h24, 8'h0F, 8'h00, 8'h01, 8'h3C, 8'h01, 8'h12, 8'h34};
      applyStimulus(2, 8, 1'b0, 1'b0, 1'b0);
      issueFetch(32'h0000_0000);
      checkOutput("directedWord0", instr, 32'h240F_0001);
      issueFetch(32'h0000_0004);
      checkOutput("directedWord1", instr, 32'h3C01_1234);
      checkOutput("directedFault", {31'b0, fetch_fault}, 32'd0);
      fetch_req = 1'b0;

      applyStimulus(5, 20, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) issueFetch(32'(i * 4));
      fetch_req = 1'b0;

      issueFetch(32'h0000_0004);
      fetch_req = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checkResetOutputs("asyncReset");
      @(negedge clk);
      reset_n = 1'b1;

      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         load_byte_valid = 1'b1;
         load_byte       = 8'($urandom);
         @(negedge clk);
      end
      load_byte_valid = 1'b0;
      for (int i = 0; i < 4; i++) issueFetch(32'(i * 4));
      fetch_req = 1'b0;

      applyStimulus(2, 6, 1'b0, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checkResetOutputs("midLoadReset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("afterResetBusy", {31'b0, load_busy}, 32'd0);
      checkOutput("afterResetCount", 32'(load_count), 32'd0);
      issueFetch(32'h0000_0000);
      issueFetch(32'h0000_0004);
      issueFetch(32'h0000_0008);
      fetch_req = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("fetchQueueDrained", 32'(fetchQ.size()), 32'd0);
      checkOutput("doneQueueDrained", 32'(doneQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
